noc_credit_link_bank: RTL and testbench

- Bank of NUM_LINKS independent credit-based router-to-router links, instantiated between router ports of the mesh.
- Each link has a configurable flit forward pipeline and an independently configurable credit-return pipeline.
- Each link also has a protocol monitor: upstream credit occupancy, sticky error flags, packet-framing FSM and saturating flit/packet counters.
- Generalises the single fixed link: multiple lanes, asymmetric pipeline depths and link-level checking.

---
 rtl/noc_link_pkg.sv | 15 +
 rtl/noc_credit_link_lane.sv | 163 ++++++++++++++++
 rtl/noc_credit_link_bank.sv | 69 ++++++
 tb/tb_noc_credit_link_bank.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// Purpose : shared types and helpers for the credit-based NoC link bank.
// Contents: link_state_t for the per-link framing FSM and credit_cnt_width(),
//           which sizes a counter that must hold 0..depth inclusive.
package noc_link_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } link_state_t;

  function automatic int credit_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_credit_link_lane.sv
// Purpose : one credit-based router-to-router link with forward and credit
//           pipelines, plus a passive monitor (credits, sticky errors, framing, stats).
// Latency : flits NUM_PIPELINE cycles, credits NUM_CREDIT_PIPELINE cycles.
// Backpressure: none; stages register every cycle and flow control is credits.
// Ports   : upstream flit in / credit out, downstream flit out / credit in,
//           err_clear in, sticky error flags, credits_avail, flit/pkt counts.
module noc_credit_link_lane
  import noc_link_pkg::*;
#(
  parameter int FLIT_WIDTH          = 128,
  parameter int DEST_WIDTH          = 6,
  parameter int NUM_PIPELINE        = 1,
  parameter int NUM_CREDIT_PIPELINE = 1,
  parameter int FLIT_BUFFER_DEPTH   = 2,
  parameter int STAT_WIDTH          = 32
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  input  logic                  err_clear,
  output logic                  err_overrun,
  output logic                  err_credit_ovf,
  output logic                  err_dest_change,
  output logic [credit_cnt_width(FLIT_BUFFER_DEPTH)-1:0] credits_avail,
  output logic [STAT_WIDTH-1:0] flit_count,
  output logic [STAT_WIDTH-1:0] pkt_count
);

  localparam int FW = FLIT_WIDTH + DEST_WIDTH + 2;
  localparam int CW = credit_cnt_width(FLIT_BUFFER_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FLIT_BUFFER_DEPTH);

  // Forward path: the whole tuple moves together so a stage with send=0
  // still shifts its (ignored) payload.
  logic [FW-1:0] fwd_in;
  logic [FW-1:0] fwd_out;
  assign fwd_in = {data_in, dest_in, is_tail_in, send_in};

  generate
    if (NUM_PIPELINE == 0) begin : g_fwd_comb
      assign fwd_out = fwd_in;
    end else begin : g_fwd_pipe
      logic [FW-1:0] stage_q [NUM_PIPELINE];
      always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
          for (int i = 0; i < NUM_PIPELINE; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= fwd_in;
          for (int i = 1; i < NUM_PIPELINE; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign fwd_out = stage_q[NUM_PIPELINE-1];
    end
  endgenerate

  assign {data_out, dest_out, is_tail_out, send_out} = fwd_out;

  // Credit path: a plain shift register, one credit per slot, never merged.
  generate
    if (NUM_CREDIT_PIPELINE == 0) begin : g_cr_comb
      assign credit_out = credit_in;
    end else begin : g_cr_pipe
      logic cr_q [NUM_CREDIT_PIPELINE];
      always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
          for (int i = 0; i < NUM_CREDIT_PIPELINE; i++) cr_q[i] <= 1'b0;
        end else begin
          cr_q[0] <= credit_in;
          for (int i = 1; i < NUM_CREDIT_PIPELINE; i++) cr_q[i] <= cr_q[i-1];
        end
      end
      assign credit_out = cr_q[NUM_CREDIT_PIPELINE-1];
    end
  endgenerate

  // Credit monitor, observed at the upstream side. A simultaneous send and
  // returned credit cancel. On an illegal step the counter clamps.
  logic [CW-1:0] credits_d;
  logic          ovr_set;
  logic          ovf_set;

  always_comb begin
    credits_d = credits_avail;
    ovr_set   = 1'b0;
    ovf_set   = 1'b0;
    if (send_in && !credit_out) begin
      if (credits_avail == '0) ovr_set = 1'b1;
      else                     credits_d = credits_avail - 1'b1;
    end else if (credit_out && !send_in) begin
      if (credits_avail == DEPTH_C) ovf_set = 1'b1;
      else                          credits_d = credits_avail + 1'b1;
    end
  end

  // Framing FSM: the head flit's dest is latched and every later flit of the
  // packet, tail included, must match it.
  link_state_t           state_q, state_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  pkt_inc;
  logic                  dest_set;

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    pkt_inc  = 1'b0;
    dest_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_in) begin
          if (is_tail_in) begin
            pkt_inc = 1'b1;
          end else begin
            dest_d  = dest_in;
            state_d = IN_PKT;
          end
        end
      end
      IN_PKT: begin
        if (send_in) begin
          if (dest_in != dest_q) dest_set = 1'b1;
          if (is_tail_in) begin
            pkt_inc = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: a new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      credits_avail   <= DEPTH_C;
      err_overrun     <= 1'b0;
      err_credit_ovf  <= 1'b0;
      err_dest_change <= 1'b0;
      state_q         <= IDLE;
      dest_q          <= '0;
      flit_count      <= '0;
      pkt_count       <= '0;
    end else begin
      credits_avail   <= credits_d;
      err_overrun     <= ovr_set  | (err_overrun     & ~err_clear);
      err_credit_ovf  <= ovf_set  | (err_credit_ovf  & ~err_clear);
      err_dest_change <= dest_set | (err_dest_change & ~err_clear);
      state_q         <= state_d;
      dest_q          <= dest_d;
      if (send_in && (flit_count != '1)) flit_count <= flit_count + 1'b1;
      if (pkt_inc && (pkt_count  != '1)) pkt_count  <= pkt_count + 1'b1;
    end
  end

endmodule

// File: rtl/noc_credit_link_bank.sv
// Purpose : bank of NUM_LINKS independent credit-based links, one lane each.
// Latency : flits NUM_PIPELINE cycles, credits NUM_CREDIT_PIPELINE cycles.
// Backpressure: none; upstream must respect credits_avail.
// Ports   : per-link arrays of the lane ports (flit in/out, credit in/out,
//           err_clear, sticky error flags, credits_avail, statistics).
module noc_credit_link_bank
  import noc_link_pkg::*;
#(
  parameter int NUM_LINKS           = 4,
  parameter int FLIT_WIDTH          = 128,
  parameter int DEST_WIDTH          = 6,
  parameter int NUM_PIPELINE        = 1,
  parameter int NUM_CREDIT_PIPELINE = 1,
  parameter int FLIT_BUFFER_DEPTH   = 2,
  parameter int STAT_WIDTH          = 32
) (
  input  logic                                  clk_noc,
  input  logic                                  rst_noc,
  input  logic [0:NUM_LINKS-1][FLIT_WIDTH-1:0]  data_in,
  input  logic [0:NUM_LINKS-1][DEST_WIDTH-1:0]  dest_in,
  input  logic [0:NUM_LINKS-1]                  is_tail_in,
  input  logic [0:NUM_LINKS-1]                  send_in,
  output logic [0:NUM_LINKS-1]                  credit_out,
  output logic [0:NUM_LINKS-1][FLIT_WIDTH-1:0]  data_out,
  output logic [0:NUM_LINKS-1][DEST_WIDTH-1:0]  dest_out,
  output logic [0:NUM_LINKS-1]                  is_tail_out,
  output logic [0:NUM_LINKS-1]                  send_out,
  input  logic [0:NUM_LINKS-1]                  credit_in,
  input  logic [0:NUM_LINKS-1]                  err_clear,
  output logic [0:NUM_LINKS-1]                  err_overrun,
  output logic [0:NUM_LINKS-1]                  err_credit_ovf,
  output logic [0:NUM_LINKS-1]                  err_dest_change,
  output logic [0:NUM_LINKS-1][credit_cnt_width(FLIT_BUFFER_DEPTH)-1:0] credits_avail,
  output logic [0:NUM_LINKS-1][STAT_WIDTH-1:0]  flit_count,
  output logic [0:NUM_LINKS-1][STAT_WIDTH-1:0]  pkt_count
);

  for (genvar l = 0; l < NUM_LINKS; l++) begin : g_lane
    noc_credit_link_lane #(
      .FLIT_WIDTH          (FLIT_WIDTH),
      .DEST_WIDTH          (DEST_WIDTH),
      .NUM_PIPELINE        (NUM_PIPELINE),
      .NUM_CREDIT_PIPELINE (NUM_CREDIT_PIPELINE),
      .FLIT_BUFFER_DEPTH   (FLIT_BUFFER_DEPTH),
      .STAT_WIDTH          (STAT_WIDTH)
    ) u_lane (
      .clk_noc         (clk_noc),
      .rst_noc         (rst_noc),
      .data_in         (data_in[l]),
      .dest_in         (dest_in[l]),
      .is_tail_in      (is_tail_in[l]),
      .send_in         (send_in[l]),
      .credit_out      (credit_out[l]),
      .data_out        (data_out[l]),
      .dest_out        (dest_out[l]),
      .is_tail_out     (is_tail_out[l]),
      .send_out        (send_out[l]),
      .credit_in       (credit_in[l]),
      .err_clear       (err_clear[l]),
      .err_overrun     (err_overrun[l]),
      .err_credit_ovf  (err_credit_ovf[l]),
      .err_dest_change (err_dest_change[l]),
      .credits_avail   (credits_avail[l]),
      .flit_count      (flit_count[l]),
      .pkt_count       (pkt_count[l])
    );
  end

endmodule

// File: tb/tb_noc_credit_link_bank.sv
// Purpose : self-checking bench for noc_credit_link_bank (2 flit stages,
//           1 credit stage, depth 2, 4-bit counters).
// Flits and credits are queued with their expected arrival cycle when issued;
// a negedge monitor pops and compares whenever send_out/credit_out is seen.
module tb_noc_credit_link_bank;

  localparam int NL = 4, FW = 16, DW = 6, NP = 2, NCP = 1, DEPTH = 2, SW = 4;

  logic clk_noc = 1'b0;
  logic rst_noc;
  logic [0:NL-1][FW-1:0] data_in, data_out;
  logic [0:NL-1][DW-1:0] dest_in, dest_out;
  logic [0:NL-1] is_tail_in, send_in, credit_out, is_tail_out, send_out;
  logic [0:NL-1] credit_in, err_clear, err_overrun, err_credit_ovf, err_dest_change;
  logic [0:NL-1][1:0] credits_avail;
  logic [0:NL-1][SW-1:0] flit_count, pkt_count;

  noc_credit_link_bank #(
    .NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(NP),
    .NUM_CREDIT_PIPELINE(NCP), .FLIT_BUFFER_DEPTH(DEPTH), .STAT_WIDTH(SW)
  ) dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
    .credit_in(credit_in), .err_clear(err_clear),
    .err_overrun(err_overrun), .err_credit_ovf(err_credit_ovf), .err_dest_change(err_dest_change),
    .credits_avail(credits_avail), .flit_count(flit_count), .pkt_count(pkt_count)
  );

  always #5 clk_noc = ~clk_noc;

  int cyc = 0;
  always @(posedge clk_noc) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int          link;
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic        tail;
    int          cyc;
  } flit_exp_t;

  typedef struct {
    int link;
    int cyc;
  } cr_exp_t;

  flit_exp_t fq[$];
  cr_exp_t   cq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every downstream flit and upstream credit must match the oldest
  // outstanding expectation of its link, including its arrival cycle.
  always @(negedge clk_noc) begin
    if (!rst_noc) begin
      for (int l = 0; l < NL; l++) begin
        if (send_out[l]) begin : mon_flit
          int idx;
          idx = -1;
          for (int i = 0; i < fq.size(); i++) if (fq[i].link == l) begin idx = i; break; end
          if (idx < 0) begin
            checks++;
            $display("FAIL unexpected_flit link %0d: got send_out=1 required 0 (cycle %0d)", l, cyc);
          end else begin
            chk($sformatf("flit_cycle_l%0d", l), 64'(cyc), 64'(fq[idx].cyc));
            chk($sformatf("flit_data_l%0d", l), 64'(data_out[l]), 64'(fq[idx].data));
            chk($sformatf("flit_dest_l%0d", l), 64'(dest_out[l]), 64'(fq[idx].dest));
            chk($sformatf("flit_tail_l%0d", l), 64'(is_tail_out[l]), 64'(fq[idx].tail));
            fq.delete(idx);
          end
        end
        if (credit_out[l]) begin : mon_cr
          int idx;
          idx = -1;
          for (int i = 0; i < cq.size(); i++) if (cq[i].link == l) begin idx = i; break; end
          if (idx < 0) begin
            checks++;
            $display("FAIL unexpected_credit link %0d: got credit_out=1 required 0 (cycle %0d)", l, cyc);
          end else begin
            chk($sformatf("credit_cycle_l%0d", l), 64'(cyc), 64'(cq[idx].cyc));
            cq.delete(idx);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_noc);
    #1;
    send_in = '0; credit_in = '0; err_clear = '0; is_tail_in = '0;
  endtask

  task automatic tick_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic send_flit(input int l, input logic [FW-1:0] d, input logic [DW-1:0] de, input logic t);
    flit_exp_t e;
    data_in[l] = d; dest_in[l] = de; is_tail_in[l] = t; send_in[l] = 1'b1;
    e.link = l; e.data = d; e.dest = de; e.tail = t; e.cyc = cyc + NP;
    fq.push_back(e);
  endtask

  task automatic give_credit(input int l);
    cr_exp_t e;
    credit_in[l] = 1'b1;
    e.link = l; e.cyc = cyc + NCP;
    cq.push_back(e);
  endtask

  task automatic drop_link(input int l);
    for (int i = fq.size() - 1; i >= 0; i--) if (fq[i].link == l) fq.delete(i);
    for (int i = cq.size() - 1; i >= 0; i--) if (cq[i].link == l) cq.delete(i);
  endtask

  task automatic chk_link(input int l, input int cr, input int fc, input int pc,
                          input logic ovr, input logic ovf, input logic dch);
    chk($sformatf("credits_l%0d", l), 64'(credits_avail[l]), 64'(cr));
    chk($sformatf("flit_count_l%0d", l), 64'(flit_count[l]), 64'(fc));
    chk($sformatf("pkt_count_l%0d", l), 64'(pkt_count[l]), 64'(pc));
    chk($sformatf("err_overrun_l%0d", l), 64'(err_overrun[l]), 64'(ovr));
    chk($sformatf("err_credit_ovf_l%0d", l), 64'(err_credit_ovf[l]), 64'(ovf));
    chk($sformatf("err_dest_change_l%0d", l), 64'(err_dest_change[l]), 64'(dch));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    rst_noc = 1'b1;
    data_in = '0; dest_in = '0; is_tail_in = '0; send_in = '0;
    credit_in = '0; err_clear = '0;
    tick(); tick(); tick();

    // Reset state on every link.
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("rst_send_out_l%0d", l), 64'(send_out[l]), 64'd0);
      chk($sformatf("rst_credit_out_l%0d", l), 64'(credit_out[l]), 64'd0);
      chk($sformatf("rst_data_out_l%0d", l), 64'(data_out[l]), 64'd0);
      chk_link(l, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    rst_noc = 1'b0;

    // Latency: flit at 10 -> out at 12; credit at 20 -> out at 21.
    tick_until(10);
    send_flit(0, 16'h00A5, 6'h03, 1'b1);
    tick();
    tick_until(20);
    give_credit(0);
    tick();
    tick_until(23);
    chk_link(0, 2, 1, 1, 1'b0, 1'b0, 1'b0);

    // Overrun on link 1: three sends, no credits back.
    chk("ovr_start_credits", 64'(credits_avail[1]), 64'd2);
    send_flit(1, 16'h0101, 6'h01, 1'b1); tick();
    chk("ovr_credits_after1", 64'(credits_avail[1]), 64'd1);
    send_flit(1, 16'h0102, 6'h01, 1'b1); tick();
    chk("ovr_credits_after2", 64'(credits_avail[1]), 64'd0);
    chk("ovr_flag_before", 64'(err_overrun[1]), 64'd0);
    send_flit(1, 16'h0103, 6'h01, 1'b1); tick();
    chk("ovr_credits_after3", 64'(credits_avail[1]), 64'd0);
    chk("ovr_flag_set", 64'(err_overrun[1]), 64'd1);
    err_clear[1] = 1'b1; tick();
    chk("ovr_flag_cleared", 64'(err_overrun[1]), 64'd0);
    give_credit(1); tick();
    give_credit(1); tick(); tick();
    chk("ovr_credits_restored", 64'(credits_avail[1]), 64'd2);

    // Simultaneous send and returned credit at credits_avail=1.
    send_flit(1, 16'h0110, 6'h02, 1'b1); tick();
    give_credit(1); tick();
    chk("same_cycle_credit_out", 64'(credit_out[1]), 64'd1);
    send_flit(1, 16'h0111, 6'h02, 1'b1); tick();
    chk_link(1, 1, 5, 5, 1'b0, 1'b0, 1'b0);
    tick();
    chk("same_cycle_credits_hold", 64'(credits_avail[1]), 64'd1);
    give_credit(1); tick(); tick();
    chk("ovf_credits_full", 64'(credits_avail[1]), 64'd2);
    give_credit(1); tick(); tick();
    chk("ovf_credits_clamped", 64'(credits_avail[1]), 64'd2);
    chk("ovf_flag_set", 64'(err_credit_ovf[1]), 64'd1);
    err_clear[1] = 1'b1; tick();
    chk("ovf_flag_cleared", 64'(err_credit_ovf[1]), 64'd0);

    // Framing on link 0: 4-flit packet, third flit changes dest.
    send_flit(0, 16'h0400, 6'h05, 1'b0); tick();
    send_flit(0, 16'h0401, 6'h05, 1'b0); give_credit(0); tick();
    send_flit(0, 16'h0402, 6'h09, 1'b0); give_credit(0); tick();
    send_flit(0, 16'h0403, 6'h05, 1'b1); give_credit(0); tick();
    give_credit(0); tick(); tick();
    chk_link(0, 2, 5, 2, 1'b0, 1'b0, 1'b1);
    send_flit(0, 16'h0404, 6'h0A, 1'b1); tick();
    chk_link(0, 1, 6, 3, 1'b0, 1'b0, 1'b1);
    err_clear[0] = 1'b1; give_credit(0); tick();
    chk("dch_flag_cleared", 64'(err_dest_change[0]), 64'd0);
    tick(); tick();
    chk("dch_credits_restored", 64'(credits_avail[0]), 64'd2);

    // Saturation on link 2 only; other links must not move.
    for (int j = 0; j < 20; j++) begin
      send_flit(2, 16'(16'h0200 + j), 6'(j), 1'b1);
      give_credit(2);
      tick();
    end
    tick(); tick();
    chk_link(2, 2, 15, 15, 1'b0, 1'b0, 1'b0);
    chk_link(0, 2, 6, 3, 1'b0, 1'b0, 1'b0);
    chk_link(1, 2, 5, 5, 1'b0, 1'b0, 1'b0);
    chk_link(3, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("idle_link3_data_out", 64'(data_out[3]), 64'd0);

    // Reset with two flits of an open packet inside the link 0 pipeline.
    send_flit(0, 16'h0600, 6'h11, 1'b0); tick();
    send_flit(0, 16'h0601, 6'h11, 1'b0); tick();
    tick();
    chk("pre_reset_send_out", 64'(send_out[0]), 64'd1);
    rst_noc = 1'b1;
    #1;
    chk("reset_send_out_now", 64'(send_out), 64'd0);
    drop_link(0);
    chk_link(0, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset_link2_flits", 64'(flit_count[2]), 64'd0);
    #1;
    rst_noc = 1'b0;
    tick();
    send_flit(0, 16'h0610, 6'h07, 1'b0); tick();
    send_flit(0, 16'h0611, 6'h07, 1'b1); tick();
    chk_link(0, 0, 2, 1, 1'b0, 1'b0, 1'b0);
    give_credit(0); tick();
    give_credit(0); tick(); tick();
    chk("post_reset_credits", 64'(credits_avail[0]), 64'd2);

    tick(); tick(); tick(); tick();
    chk("flits_outstanding", 64'(fq.size()), 64'd0);
    chk("credits_outstanding", 64'(cq.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
